// File: rtl/gray_pkg.sv
// Shared types and constants for the grayscale-to-RGB colormap pipeline.
// Stage payload bundles are packed structs so stages move them as one word.
package gray_pkg;

    localparam int   PIX_W     = 8;
    localparam int   SEG_W     = 2;
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_JET  = 1'b1;

    typedef struct packed {
        logic             mode;
        logic             last;
        logic [PIX_W-1:0] gray;
    } pix_t;

    typedef struct packed {
        pix_t             pix;
        logic [SEG_W-1:0] seg;
        logic [PIX_W-1:0] ramp;
        logic [PIX_W-1:0] inv;
    } s1_t;

    typedef struct packed {
        logic             last;
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/gray2rgb_jet_lut.sv
// Combinational jet heat-map: four 64-code segments built from
// the shifted ramp and its complement, so no adders are involved.
module gray2rgb_jet_lut
    import gray_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    input  logic [PIX_W-1:0] ramp,
    input  logic [PIX_W-1:0] inv,
    output logic [PIX_W-1:0] r,
    output logic [PIX_W-1:0] g,
    output logic [PIX_W-1:0] b
);

    always_comb begin
        r = '0;
        g = '0;
        b = '0;
        unique case (seg)
            2'd0: begin
                g = ramp;
                b = '1;
            end
            2'd1: begin
                g = '1;
                b = inv;
            end
            2'd2: begin
                r = ramp;
                g = '1;
            end
            2'd3: begin
                r = '1;
                g = inv;
            end
        endcase
    end

endmodule

// File: rtl/gray2rgb_colormap.sv
// Three-stage gray to RGB expander (passthrough or jet) with
// valid/ready backpressure and bubble collapsing between stages.
module gray2rgb_colormap
    import gray_pkg::*;
#(
    parameter int INT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_WIDTH-1:0] gray,
    input  logic                 din_valid,
    input  logic                 din_mode,
    input  logic                 din_last,
    output logic                 din_ready,
    output logic [INT_WIDTH-1:0] R,
    output logic [INT_WIDTH-1:0] G,
    output logic [INT_WIDTH-1:0] B,
    output logic                 dout_last,
    output logic                 dout_valid,
    input  logic                 dout_ready
);

    logic v0, v1, v2;
    logic adv0, adv1, adv2;
    pix_t s0;
    s1_t  s1;
    rgb_t s2;

    logic [PIX_W-1:0] jet_r, jet_g, jet_b;
    logic [PIX_W-1:0] ramp_nxt;
    rgb_t             rgb_nxt;

    // A stage may move whenever everything downstream can make room.
    assign adv2      = ~v2 | dout_ready;
    assign adv1      = ~v1 | adv2;
    assign adv0      = ~v0 | adv1;
    assign din_ready = adv0;

    assign ramp_nxt = {s0.gray[5:0], 2'b00};

    gray2rgb_jet_lut u_lut (
        .seg  (s1.seg),
        .ramp (s1.ramp),
        .inv  (s1.inv),
        .r    (jet_r),
        .g    (jet_g),
        .b    (jet_b)
    );

    always_comb begin
        rgb_nxt      = '0;
        rgb_nxt.last = s1.pix.last;
        if (s1.pix.mode == MODE_JET) begin
            rgb_nxt.r = jet_r;
            rgb_nxt.g = jet_g;
            rgb_nxt.b = jet_b;
        end else begin
            rgb_nxt.r = s1.pix.gray;
            rgb_nxt.g = s1.pix.gray;
            rgb_nxt.b = s1.pix.gray;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            s0 <= '0;
            s1 <= '0;
            s2 <= '0;
        end else begin
            if (adv0) begin
                v0 <= din_valid;
                if (din_valid) begin
                    s0 <= '{mode: din_mode, last: din_last,
                            gray: gray};
                end
            end
            if (adv1) begin
                v1 <= v0;
                if (v0) begin
                    s1.pix  <= s0;
                    s1.seg  <= s0.gray[7:6];
                    s1.ramp <= ramp_nxt;
                    s1.inv  <= ~ramp_nxt;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2 <= rgb_nxt;
                end
            end
        end
    end

    assign dout_valid = v2;
    assign dout_last  = s2.last;
    assign R          = s2.r;
    assign G          = s2.g;
    assign B          = s2.b;

endmodule

// File: tb/tb_gray2rgb_colormap.sv
// Randomised bench for gray2rgb_colormap against an arithmetic
// colour model and an in-order scoreboard queue.
module tb_gray2rgb_colormap;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gray;
    logic       din_valid, din_mode, din_last, din_ready;
    logic [7:0] R, G, B;
    logic       dout_last, dout_valid, dout_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [24:0] q[$];
    int          cons_cyc[$];
    bit          cons_last[$];
    int          acc_cyc[$];

    gray2rgb_colormap #(.INT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray       (gray),
        .din_valid  (din_valid),
        .din_mode   (din_mode),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .R          (R),
        .G          (G),
        .B          (B),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] model(input bit mode, input bit last,
                                          input logic [7:0] g);
        int s, ramp, inv, r, gg, b;
        s    = int'(g) / 64;
        ramp = (int'(g) % 64) * 4;
        inv  = 255 - ramp;
        if (!mode) begin
            r = int'(g); gg = int'(g); b = int'(g);
        end else begin
            case (s)
                0:       begin r = 0;    gg = ramp; b = 255;  end
                1:       begin r = 0;    gg = 255;  b = inv;  end
                2:       begin r = ramp; gg = 255;  b = 0;    end
                default: begin r = 255;  gg = inv;  b = 0;    end
            endcase
        end
        return {last, 8'(r), 8'(gg), 8'(b)};
    endfunction

    // Scoreboard: every visible output must match the oldest accepted pixel.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (dout_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(dout_valid), 32'd0);
                end else begin
                    check("out", 32'({dout_last, R, G, B}), 32'(q[0]));
                    if (dout_ready) begin
                        void'(q.pop_front());
                        cons_cyc.push_back(cyc);
                        cons_last.push_back(dout_last);
                    end
                end
            end
            if (din_valid && din_ready) begin
                q.push_back(model(din_mode, din_last, gray));
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input bit mode, input logic [7:0] g, input bit last);
        bit ok;
        ok        = 1'b0;
        din_valid = 1'b1;
        din_mode  = mode;
        gray      = g;
        din_last  = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = din_ready;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = dout_valid;
        end
        if (!ok) check("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    logic [7:0]  bnd_g[7]   = '{8'h00, 8'h3F, 8'h40, 8'h7F,
                                8'h80, 8'hC0, 8'hFF};
    logic [23:0] bnd_rgb[7] = '{24'h0000FF, 24'h00FCFF, 24'h00FFFF,
                                24'h00FF03, 24'h00FF00, 24'hFFFF00,
                                24'hFF0300};
    logic [7:0]  bp_g[6]    = '{8'h11, 8'h52, 8'h93, 8'hD4, 8'h25, 8'hE6};

    initial begin
        int k, a0, nl;
        bit acc;
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din_mode   = 1'b0;
        din_last   = 1'b0;
        gray       = '0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_rgb", 32'({dout_last, R, G, B}), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd1);

        // Latency and single-cycle output pulse
        @(posedge clk);
        #1 dout_ready = 1'b1;
        send(1'b0, 8'h5A, 1'b0);
        check("lat_e1", 32'(dout_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e2", 32'(dout_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e3", 32'(dout_valid), 32'd1);
        check("lat_rgb", 32'({R, G, B}), 32'h5A5A5A);
        @(posedge clk); #1;
        check("lat_e4", 32'(dout_valid), 32'd0);

        for (int i = 0; i < 7; i++) begin
            send(1'b1, bnd_g[i], 1'b0);
            wait_out();
            check($sformatf("jet_%02h", bnd_g[i]), 32'({R, G, B}),
                  32'(bnd_rgb[i]));
        end
        drain();

        // Backpressure: pipeline fills with three, then stalls input
        dout_ready = 1'b0;
        k          = 0;
        din_valid  = 1'b1;
        din_mode   = 1'b1;
        din_last   = 1'b0;
        gray       = bp_g[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 6) gray = bp_g[k];
                else din_valid = 1'b0;
            end
        end
        check("bp_accepted", 32'(k), 32'd3);
        check("bp_ready_low", 32'(din_ready), 32'd0);
        dout_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(din_ready), 32'd1);
        for (int c = 0; c < 100 && k < 6; c++) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 6) gray = bp_g[k];
                else din_valid = 1'b0;
            end
        end
        drain();

        // Full-rate ramp with last on the final code
        cons_cyc.delete();
        cons_last.delete();
        acc_cyc.delete();
        din_mode = 1'b1;
        for (int g = 0; g < 256; g++) begin
            din_valid = 1'b1;
            gray      = 8'(g);
            din_last  = (g == 255);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
        drain();
        a0 = (acc_cyc.size() > 0) ? acc_cyc[0] : 0;
        check("ramp_count", 32'(cons_cyc.size()), 32'd256);
        if (cons_cyc.size() == 256) begin
            check("ramp_first", 32'(cons_cyc[0] - a0), 32'd3);
            check("ramp_span", 32'(cons_cyc[255] - cons_cyc[0]), 32'd255);
            nl = 0;
            foreach (cons_last[i]) nl += int'(cons_last[i]);
            check("ramp_nlast", 32'(nl), 32'd1);
            check("ramp_last_pos", 32'(cons_last[255]), 32'd1);
        end

        // Random traffic on both sides
        for (int c = 0; c < 600; c++) begin
            din_valid  = 1'($urandom_range(0, 1));
            din_mode   = 1'($urandom_range(0, 1));
            din_last   = ($urandom_range(0, 7) == 0);
            gray       = 8'($urandom_range(0, 255));
            dout_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        drain();

        // Asynchronous reset with a full pipeline
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 8'(8'h30 + i), 1'b1);
        check("rst_full", 32'(din_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_rgb", 32'({dout_last, R, G, B}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dout_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_stale", 32'(dout_valid), 32'd0);
        send(1'b0, 8'h10, 1'b0);
        wait_out();
        check("arst_new", 32'({R, G, B}), 32'h101010);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gray2rgb_colormap.md
Name: gray2rgb_colormap

Overview:
- Consumes the 8-bit grayscale pixel stream produced by the RGB-to-grayscale stage and expands each pixel back to 24-bit RGB for display or debug output.
- Two mapping modes:
  - Mode 0, passthrough: R=G=B=gray.
  - Mode 1, "jet" false-colour heat map: piecewise-linear over four 64-code segments.
- 3-stage pipeline with per-stage valid bits, valid/ready backpressure and bubble collapsing.
- A sideband end-of-line/frame flag travels alongside each pixel.

Parameters:
- INT_WIDTH, 8, pixel component width. Only 8 is supported; the colormap segment math is fixed to 8 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gray  input  INT_WIDTH  grayscale pixel in.
- din_valid  input  1  gray, din_mode and din_last are valid this cycle.
- din_mode  input  1  0 = passthrough, 1 = jet. Sampled per pixel.
- din_last  input  1  last pixel of line/frame; forwarded unchanged.
- din_ready  output  1  block accepts input this cycle.
- R  output  INT_WIDTH  red out.
- G  output  INT_WIDTH  green out.
- B  output  INT_WIDTH  blue out.
- dout_last  output  1  forwarded last flag.
- dout_valid  output  1  R, G, B and dout_last are valid.
- dout_ready  input  1  downstream accepts output.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits cleared; all data registers cleared.
  - Outputs: R=G=B=0, dout_valid=0, dout_last=0.
  - din_ready=1 once reset is released; it is don't-care while reset is asserted.
  - Reset mid-stream drops every in-flight pixel silently.
- Transfer rule: a transfer occurs on a rising edge where valid and ready are both high, at both input and output.
  - A pixel is accepted only when din_valid & din_ready.
  - A pixel is consumed only when dout_valid & dout_ready.
- Pipeline stages (valid bits v0, v1, v2; v2 drives dout_valid):
  - S0: registers gray, mode and last.
  - S1: computes seg = gray[7:6], ramp = {gray[5:0],2'b00} (0..252) and inv = ~ramp (255..3); carries mode, gray and last.
  - S2: selects R/G/B and registers them as outputs.
- Advance rules (bubble collapsing):
  - adv2 = ~v2 | dout_ready.
  - adv1 = ~v1 | adv2.
  - adv0 = ~v0 | adv1.
  - din_ready = adv0.
  - A stage that advances with no incoming valid data clears its valid bit.
  - A stage that does not advance holds all of its registers.
- Latency:
  - Exactly 3 clk edges from an accepted input to dout_valid, when dout_ready is held high.
  - Throughput is 1 pixel/cycle.
- Capacity: at most 3 pixels in flight.
  - With dout_ready=0 and a full pipeline, din_ready=0.
  - din_ready rises in the same cycle dout_ready rises (combinational path).
- Ordering: strict FIFO; no pixel is duplicated or lost.
- Output stability: while dout_valid=1 and dout_ready=0, R, G, B and dout_last hold stable.
- Mode 0: R=G=B=gray.
- Mode 1 (jet), by seg:
  - seg 0 (0x00-0x3F): R=0x00, G=ramp, B=0xFF.
  - seg 1 (0x40-0x7F): R=0x00, G=0xFF, B=inv.
  - seg 2 (0x80-0xBF): R=ramp, G=0xFF, B=0x00.
  - seg 3 (0xC0-0xFF): R=0xFF, G=inv, B=0x00.
- Arithmetic: no adders are needed. The ramp is a shift; inv is a bitwise complement. There is no overflow and no clamping.
- Mode switching: mode is per pixel, so switching modes between consecutive pixels is legal and takes effect on exactly that pixel.
- Simultaneous events: output consume and input accept in the same cycle with a full pipeline is legal and sustains full throughput.

Decomposition:
- Shared package gray_pkg holds:
  - Constants: PIX_W=8, MODE_PASS=1'b0, MODE_JET=1'b1, SEG_W=2.
  - A typedef for the {mode, last, gray} stage payload.
- One natural sub-module, gray2rgb_jet_lut:
  - Purely combinational: gray to {R,G,B} for jet mode.
  - Instantiated between S1 and S2.
  - Verified standalone with an exhaustive 256-code sweep.

Test Plan:
1. Mode 0, gray=0x5A, dout_ready=1 -> dout_valid for exactly one cycle, 3 edges after accept, R=G=B=0x5A.
2. Mode 1 segment boundaries:
   - gray 0x00 -> (00,00,FF)
   - gray 0x3F -> (00,FC,FF)
   - gray 0x40 -> (00,FF,FF)
   - gray 0x7F -> (00,FF,03)
   - gray 0x80 -> (00,FF,00)
   - gray 0xC0 -> (FF,FF,00)
   - gray 0xFF -> (FF,03,00)
3. Backpressure: 6 back-to-back pixels, dout_ready=0 for 10 cycles then 1.
   - Exactly 3 pixels accepted before din_ready=0.
   - Outputs held stable during the stall.
   - All 6 pixels emerge in order, each exactly once.
4. Throughput: ramp 0x00..0xFF, din_last on 0xFF, dout_ready=1.
   - 256 outputs on consecutive cycles, the first 3 cycles after the first accept.
   - dout_last=1 only on the 0xFF output.
5. Random dout_ready (50%) plus random din_valid with mixed modes -> the scoreboard matches the reference model; no loss, duplication or reordering.
6. rst_n asserted mid-stream with 3 pixels in flight.
   - dout_valid=0 and RGB=0 immediately, asynchronously.
   - After release, a new pixel gray=0x10 in mode 0 yields (10,10,10) with no stale output.
